// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipeline.
// Fetches one word per cycle from a req/ready instruction memory. A word that
// arrives while decode is stalled is parked in a one-entry hold buffer. The word
// that follows an immediate-class instruction is tagged so that decode treats it
// as data. A branch redirect flushes IF/ID and restarts fetch at the target.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  IMM_OPCODE = 3'b101,
    parameter logic [15:0] NOP_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemReady,
    output logic [15:0] instruction,
    output logic [15:0] pcOut,
    output logic        valid,
    output logic        isImmWord
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [15:0] pc, pc_d;
    logic        req, req_d;
    logic        imm_pending, imm_pending_d;

    // IF/ID register next values
    logic [15:0] instr_d, pc_out_d;
    logic        valid_d, imm_word_d;

    // One-entry buffer for a word that arrived during a stall
    logic [15:0] hold_instr, hold_instr_d;
    logic [15:0] hold_pc, hold_pc_d;
    logic        hold_imm, hold_imm_d;

    // Word selected for loading into IF/ID this cycle
    logic        load;
    logic [15:0] load_instr, load_pc;
    logic        load_imm;

    logic        accept;

    assign accept   = req && imemReady;
    assign imemReq  = req;
    assign imemAddr = pc;

    // Next-state, IF/ID and hold-buffer update logic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d       = state;
        pc_d          = pc;
        req_d         = req;
        imm_pending_d = imm_pending;
        instr_d       = instruction;
        pc_out_d      = pcOut;
        valid_d       = valid;
        imm_word_d    = isImmWord;
        hold_instr_d  = hold_instr;
        hold_pc_d     = hold_pc;
        hold_imm_d    = hold_imm;
        load          = 1'b0;
        load_instr    = imemData;
        load_pc       = pc;
        load_imm      = imm_pending;

        if (branchTaken) begin
            // Redirect wins over everything: any response landing now is dropped.
            pc_d          = branchTarget;
            req_d         = 1'b0;
            state_d       = REDIR;
            imm_pending_d = 1'b0;
            instr_d       = NOP_WORD;
            valid_d       = 1'b0;
            imm_word_d    = 1'b0;
            hold_instr_d  = NOP_WORD;
            hold_pc_d     = 16'h0000;
            hold_imm_d    = 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    req_d = 1'b1;
                    if (accept) begin
                        pc_d = pc + 16'd1;
                        if (!stall) begin
                            load = 1'b1;
                        end else begin
                            hold_instr_d = imemData;
                            hold_pc_d    = pc;
                            hold_imm_d   = imm_pending;
                            state_d      = HOLD;
                            req_d        = 1'b0;
                        end
                    end else if (!stall) begin
                        // Nothing arrived and decode moves on: insert a bubble.
                        instr_d    = NOP_WORD;
                        valid_d    = 1'b0;
                        imm_word_d = 1'b0;
                    end
                end
                HOLD: begin
                    req_d = 1'b0;
                    if (!stall) begin
                        load       = 1'b1;
                        load_instr = hold_instr;
                        load_pc    = hold_pc;
                        load_imm   = hold_imm;
                        state_d    = FETCH;
                        req_d      = 1'b1;
                    end
                end
                REDIR: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                end
            endcase

            if (load) begin
                instr_d    = load_instr;
                pc_out_d   = load_pc;
                valid_d    = 1'b1;
                imm_word_d = load_imm;
                // An immediate word clears the flag and never re-arms it.
                imm_pending_d = !load_imm && (load_instr[15:13] == IMM_OPCODE);
            end
        end
    end

    // State, PC, IF/ID and hold-buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req         <= 1'b0;
            imm_pending <= 1'b0;
            instruction <= NOP_WORD;
            pcOut       <= 16'h0000;
            valid       <= 1'b0;
            isImmWord   <= 1'b0;
            hold_instr  <= NOP_WORD;
            hold_pc     <= 16'h0000;
            hold_imm    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_d;
            pc          <= pc_d;
            req         <= req_d;
            imm_pending <= imm_pending_d;
            instruction <= instr_d;
            pcOut       <= pc_out_d;
            valid       <= valid_d;
            isImmWord   <= imm_word_d;
            hold_instr  <= hold_instr_d;
            hold_pc     <= hold_pc_d;
            hold_imm    <= hold_imm_d;
        end
    end

endmodule
